// File: rtl/seg7_decode_monitor.sv
// Loopback monitor: synchronizes a 7-segment pattern, waits for it to be stable, decodes it
// to BCD and checks the 0..9 wrap-around count. Optional SEG7_MON_ERRCNT_EN enables err_count.
module seg7_decode_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             invalid,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t     state;
  logic [6:0] s1, s2, s2_prev;
  logic [7:0] stab_cnt;
  logic       accept;
  logic       pat_valid, pat_blank;
  logic [3:0] pat_digit, next_digit;
  logic       in_seq;

  always_comb begin
    pat_valid = 1'b1;
    pat_digit = 4'd0;
    unique case (s2)
      7'h3F: pat_digit = 4'd0;
      7'h06: pat_digit = 4'd1;
      7'h5B: pat_digit = 4'd2;
      7'h4F: pat_digit = 4'd3;
      7'h66: pat_digit = 4'd4;
      7'h6D: pat_digit = 4'd5;
      7'h7D: pat_digit = 4'd6;
      7'h07: pat_digit = 4'd7;
      7'h7F: pat_digit = 4'd8;
      7'h6F: pat_digit = 4'd9;
      default: pat_valid = 1'b0;
    endcase
  end

  assign pat_blank  = (s2 == 7'h00);
  // Fires once per stable pattern: the counter only passes through STABLE_CYCLES-1 once.
  assign accept     = (s2 == s2_prev) && (stab_cnt == 8'(STABLE_CYCLES - 1));
  assign next_digit = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
  assign in_seq     = (pat_digit == next_digit) || (pat_digit == digit);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      s2_prev  <= '0;
      stab_cnt <= '0;
    end else begin
      s1      <= seg_in;
      s2      <= s1;
      s2_prev <= s2;
      if (s2 != s2_prev)                        stab_cnt <= '0;
      else if (stab_cnt != 8'(STABLE_CYCLES))   stab_cnt <= stab_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= UNLOCKED;
      locked      <= 1'b0;
      digit       <= '0;
      digit_valid <= 1'b0;
      invalid     <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      digit_valid <= 1'b0;
      invalid     <= 1'b0;
      seq_err     <= 1'b0;
      if (accept && !pat_blank) begin
        if (pat_valid) begin
          digit       <= pat_digit;
          digit_valid <= 1'b1;
          if (state == UNLOCKED) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end else if (!in_seq) begin
            seq_err <= 1'b1;
          end
        end else begin
          // Invalid pattern drops lock; digit keeps the last good value.
          invalid <= 1'b1;
          state   <= UNLOCKED;
          locked  <= 1'b0;
        end
      end
    end
  end

`ifdef SEG7_MON_ERRCNT_EN
  logic             err_evt;
  logic [ERR_W-1:0] err_q;

  assign err_evt = accept && !pat_blank &&
                   (!pat_valid || ((state == LOCKED) && !in_seq));

  always_ff @(posedge clk) begin
    if (rst)                            err_q <= '0;
    else if (err_evt && (err_q != '1))  err_q <= err_q + 1'b1;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Directed bench for seg7_decode_monitor: lock, counting, sequence/invalid errors,
// glitch rejection, blanking, error-count saturation and reset-before-accept.
module tb_seg7_decode_monitor;

`ifdef SEG7_MON_ERRCNT_EN
  localparam bit ERRCNT_EN = 1'b1;
`else
  localparam bit ERRCNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic [3:0] digit;
  logic       digit_valid, invalid, seq_err, locked;
  logic [7:0] err_count;

  seg7_decode_monitor #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .digit(digit), .digit_valid(digit_valid),
    .invalid(invalid), .seq_err(seq_err), .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int n_chk  = 0;
  int n_pass = 0;
  int cnt_dv, cnt_inv, cnt_seq, cnt_both;
  int exp_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clr();
    cnt_dv = 0; cnt_inv = 0; cnt_seq = 0; cnt_both = 0;
  endtask

  // Drive a pattern for n cycles, tallying output pulses sampled 1 time unit after each edge.
  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (digit_valid) cnt_dv++;
      if (invalid)     cnt_inv++;
      if (seq_err)     cnt_seq++;
      if (invalid && seq_err) cnt_both++;
    end
  endtask

  function automatic int exp_ec();
    return ERRCNT_EN ? exp_err : 0;
  endfunction

  function automatic void bump_err();
    if (exp_err < 255) exp_err++;
  endfunction

  initial begin
    rst = 1'b1; seg_in = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digit", digit, 0);
    chk("rst_dv", digit_valid, 0);
    chk("rst_inv", invalid, 0);
    chk("rst_seq", seq_err, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err_count, 0);
    rst = 1'b0;
    clr(); hold(7'h00, 10);
    chk("blank_init_pulses", cnt_dv + cnt_inv + cnt_seq, 0);

    // First lock: accept lands on the 7th edge after the change (E0+6).
    seg_in = 7'h3F;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 6) chk("lock_early_dv", digit_valid, 0);
      if (i == 7) begin
        chk("lock_dv", digit_valid, 1);
        chk("lock_digit", digit, 0);
        chk("lock_locked", locked, 1);
        chk("lock_err", err_count, exp_ec());
      end
      if (i == 8) chk("lock_dv_end", digit_valid, 0);
    end
    hold(7'h3F, 12);

    // Count 1..9 then wrap to 0.
    for (int k = 1; k <= 10; k++) begin
      clr(); hold(pats[k % 10], 20);
      chk("cnt_dv", cnt_dv, 1);
      chk("cnt_digit", digit, k % 10);
      chk("cnt_seq", cnt_seq, 0);
    end

    for (int k = 1; k <= 3; k++) hold(pats[k], 20);
    chk("at3_digit", digit, 3);
    clr(); hold(7'h66, 20);
    chk("d4_dv", cnt_dv, 1);
    chk("d4_seq", cnt_seq, 0);
    chk("d4_digit", digit, 4);
    clr(); hold(7'h7F, 20);
    bump_err();
    chk("jump_dv", cnt_dv, 1);
    chk("jump_seq", cnt_seq, 1);
    chk("jump_digit", digit, 8);
    chk("jump_err", err_count, exp_ec());

    clr(); hold(7'h49, 20);
    bump_err();
    chk("inv_pulse", cnt_inv, 1);
    chk("inv_dv", cnt_dv, 0);
    chk("inv_locked", locked, 0);
    chk("inv_digit_hold", digit, 8);
    chk("inv_err", err_count, exp_ec());
    clr(); hold(7'h06, 20);
    chk("relock_dv", cnt_dv, 1);
    chk("relock_seq", cnt_seq, 0);
    chk("relock_digit", digit, 1);
    chk("relock_locked", locked, 1);

    clr(); hold(7'h00, 20);
    chk("blank_pulses", cnt_dv + cnt_inv + cnt_seq, 0);
    chk("blank_digit", digit, 1);
    chk("blank_locked", locked, 1);

    clr(); hold(7'h06, 3); hold(7'h5B, 20);
    chk("glitch_dv", cnt_dv, 1);
    chk("glitch_digit", digit, 2);
    chk("glitch_seq", cnt_seq, 0);

    // 260 invalid accepts, alternating two invalid patterns so each one re-accepts.
    clr();
    for (int k = 0; k < 130; k++) begin
      hold(7'h49, 8); bump_err();
      hold(7'h01, 8); bump_err();
    end
    chk("sat_inv_cnt", cnt_inv, 260);
    chk("sat_dv_cnt", cnt_dv, 0);
    chk("sat_both", cnt_both, 0);
    chk("sat_locked", locked, 0);
    chk("sat_err", err_count, exp_ec());

    // Reset sampled on what would have been the accept edge.
    seg_in = 7'h3F;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rstacc_dv", digit_valid, 0);
    chk("rstacc_locked", locked, 0);
    chk("rstacc_digit", digit, 0);
    chk("rstacc_err", err_count, 0);
    rst = 1'b0;
    exp_err = 0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (i == 6) chk("post_rst_early", digit_valid, 0);
      if (i == 7) begin
        chk("post_rst_dv", digit_valid, 1);
        chk("post_rst_locked", locked, 1);
        chk("post_rst_err", err_count, exp_ec());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
